// File: rtl/axi_arb_2m1s_pkg.sv
// axi_arb_2m1s_pkg
//   Shared definitions for the two-master / one-slave AXI arbiter:
//   response encodings, the arbiter state encoding and a small helper
//   used to recognise the read-transfer states.
package axi_arb_2m1s_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD0  = 2'd1,
        ARB_RD1  = 2'd2,
        ARB_WR1  = 2'd3
    } arb_state_t;

    function automatic logic is_read_state(input arb_state_t s);
        return (s == ARB_RD0) || (s == ARB_RD1);
    endfunction

endpackage

// File: rtl/axi_arb_2m1s_rr2.sv
// axi_arb_2m1s_rr2
//   Two-input round-robin picker. Combinational.
//   Ports:
//     req[1:0]  in   request from master 0 / master 1
//     last      in   index of the master granted most recently
//     gnt[1:0]  out  one-hot grant (all zero when nothing is requested)
module axi_arb_2m1s_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the master that did not win last time is picked.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_arb_2m1s.sv
// axi_arb_2m1s
//   Shares one AXI4-subset slave port between the IFU (m0, read only) and
//   the LSU (m1, read and write). One transaction is outstanding at a time;
//   the grant is registered and round-robin, after which the granted
//   master's channels are routed combinationally to the slave.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     m0_ar*, m0_r*         IFU read address / read data
//     m1_ar*, m1_r*         LSU read address / read data
//     m1_aw*, m1_w*, m1_b*  LSU write address / write data / write response
//     s_ar*, s_r*, s_aw*, s_w*, s_b*  slave side, directions reversed
module axi_arb_2m1s
    import axi_arb_2m1s_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic [ID_W-1:0]     m0_rid,
    output logic                m0_rlast,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic [ID_W-1:0]     m1_rid,
    output logic                m1_rlast,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic [ID_W-1:0]     s_rid,
    input  logic                s_rlast,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp
);

    arb_state_t state, state_d;
    logic       rr_last, rr_last_d;
    logic       ar_done, aw_done, w_done;
    logic [1:0] gnt;

    axi_arb_2m1s_rr2 u_rr2 (
        .req  ({m1_arvalid | m1_awvalid, m0_arvalid}),
        .last (rr_last),
        .gnt  (gnt)
    );

    // Payload fields are steered unconditionally; only valid/ready are gated.
    assign s_araddr = (state == ARB_RD1) ? m1_araddr : m0_araddr;
    assign s_arid   = (state == ARB_RD1) ? m1_arid   : m0_arid;
    assign s_awaddr = m1_awaddr;
    assign s_wdata  = m1_wdata;
    assign s_wstrb  = m1_wstrb;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rid   = s_rid;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rid   = s_rid;
    assign m1_rlast = s_rlast;
    assign m1_bresp = s_bresp;

    // State, round-robin history and per-channel done flags. The done flags
    // keep a channel from re-issuing after its handshake and are cleared on
    // every return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            rr_last <= 1'b1;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            rr_last <= rr_last_d;
            if (state_d == ARB_IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (is_read_state(state) && s_arvalid && s_arready) ar_done <= 1'b1;
                if (state == ARB_WR1 && s_awvalid && s_awready)     aw_done <= 1'b1;
                if (state == ARB_WR1 && s_wvalid && s_wready)       w_done  <= 1'b1;
            end
        end
    end

    // Grant decision in IDLE and handshake routing in the transfer states.
    // An m1 grant with both ar and aw pending serves the read first.
    always_comb begin
        state_d    = state;
        rr_last_d  = rr_last;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (gnt[0]) begin
                    state_d   = ARB_RD0;
                    rr_last_d = 1'b0;
                end else if (gnt[1]) begin
                    state_d   = m1_arvalid ? ARB_RD1 : ARB_WR1;
                    rr_last_d = 1'b1;
                end
            end
            ARB_RD0: begin
                s_arvalid  = m0_arvalid & ~ar_done;
                m0_arready = s_arready & ~ar_done;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
                if (s_rvalid && m0_rready && s_rlast) state_d = ARB_IDLE;
            end
            ARB_RD1: begin
                s_arvalid  = m1_arvalid & ~ar_done;
                m1_arready = s_arready & ~ar_done;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
                if (s_rvalid && m1_rready && s_rlast) state_d = ARB_IDLE;
            end
            ARB_WR1: begin
                s_awvalid  = m1_awvalid & ~aw_done;
                m1_awready = s_awready & ~aw_done;
                s_wvalid   = m1_wvalid & ~w_done;
                m1_wready  = s_wready & ~w_done;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
                if (s_bvalid && m1_bready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A granted master must hold its request valid until the handshake.
    assert property (@(posedge clk) disable iff (rst)
        (state == ARB_RD0 && !ar_done && m0_arvalid && !s_arready) |=> m0_arvalid);
    assert property (@(posedge clk) disable iff (rst)
        (state == ARB_RD1 && !ar_done && m1_arvalid && !s_arready) |=> m1_arvalid);
    assert property (@(posedge clk) disable iff (rst)
        (state == ARB_WR1 && !aw_done && m1_awvalid && !s_awready) |=> m1_awvalid);
    assert property (@(posedge clk) disable iff (rst)
        (state == ARB_WR1 && !w_done && m1_wvalid && !s_wready) |=> m1_wvalid);

endmodule

// File: tb/tb_axi_arb_2m1s.sv
// tb_axi_arb_2m1s
//   Bench for axi_arb_2m1s. A small CLINT-like slave model answers on the
//   slave side (mtime at 0x1001_0000/4, SLVERR at 0x1001_0008, a fixed
//   pattern elsewhere). Expected responses and grant order are queued when
//   requests are issued and compared as the masters receive them.
module tb_axi_arb_2m1s;
    import axi_arb_2m1s_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 1, m0_rlast;
    logic [31:0] m0_araddr = 0, m0_rdata;
    logic [3:0]  m0_arid = 0, m0_rid;
    logic [1:0]  m0_rresp;
    logic m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 1, m1_rlast;
    logic [31:0] m1_araddr = 0, m1_rdata;
    logic [3:0]  m1_arid = 0, m1_rid;
    logic [1:0]  m1_rresp;
    logic m1_awvalid = 0, m1_awready, m1_wvalid = 0, m1_wready, m1_bvalid, m1_bready = 1;
    logic [31:0] m1_awaddr = 0, m1_wdata = 0;
    logic [3:0]  m1_wstrb = 0;
    logic [1:0]  m1_bresp;

    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [1:0]  s_rresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    rexp_t      q0[$];
    rexp_t      q1[$];
    logic [1:0] bq[$];
    int         grant_q[$];

    axi_arb_2m1s #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rid(m0_rid), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rid(m1_rid), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed data pattern returned for ordinary memory addresses.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [33:0] slave_read(input logic [31:0] a, input logic [63:0] t);
        logic [63:0] tv;
        tv = t;
        case (a)
            32'h1001_0000: return {RESP_OKAY, tv[31:0]};
            32'h1001_0004: return {RESP_OKAY, tv[63:32]};
            32'h1001_0008: return {RESP_SLVERR, 32'h0};
            default:       return {RESP_OKAY, mem_word(a)};
        endcase
    endfunction

    // Slave model: one read and one write in flight, single-beat bursts,
    // read data one cycle after the address handshake.
    logic [63:0] sl_mtime;
    logic        sl_rpend, sl_aw_got, sl_w_got, sl_bvalid;
    logic [31:0] sl_rdata, sl_awaddr, sl_wdata;
    logic [3:0]  sl_rid, sl_wstrb;
    logic [1:0]  sl_rresp;

    assign s_arready = !sl_rpend;
    assign s_rvalid  = sl_rpend;
    assign s_rdata   = sl_rdata;
    assign s_rresp   = sl_rresp;
    assign s_rid     = sl_rid;
    assign s_rlast   = 1'b1;
    assign s_awready = !sl_aw_got;
    assign s_wready  = !sl_w_got;
    assign s_bvalid  = sl_bvalid;
    assign s_bresp   = (sl_awaddr == 32'h1001_0008) ? RESP_SLVERR : RESP_OKAY;

    always @(posedge clk) begin
        if (rst) begin
            sl_mtime  <= 64'd0;
            sl_rpend  <= 1'b0;
            sl_aw_got <= 1'b0;
            sl_w_got  <= 1'b0;
            sl_bvalid <= 1'b0;
        end else begin
            sl_mtime <= sl_mtime + 64'd1;
            if (s_arvalid && s_arready) begin
                sl_rpend               <= 1'b1;
                sl_rid                 <= s_arid;
                {sl_rresp, sl_rdata}   <= slave_read(s_araddr, sl_mtime);
            end else if (s_rvalid && s_rready) begin
                sl_rpend <= 1'b0;
            end
            if (s_awvalid && s_awready) begin
                sl_aw_got <= 1'b1;
                sl_awaddr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                sl_w_got <= 1'b1;
                sl_wdata <= s_wdata;
                sl_wstrb <= s_wstrb;
            end
            if (sl_aw_got && sl_w_got && !sl_bvalid) sl_bvalid <= 1'b1;
            if (s_bvalid && s_bready) begin
                sl_bvalid <= 1'b0;
                sl_aw_got <= 1'b0;
                sl_w_got  <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitors: grant order and IDLE bubble at the slave AR handshake,
    // responses against the per-master queues, plus quiet-channel counters.
    int  mon_who;
    int  last_rfire_cyc = -1;
    bit  bubble_en = 0;
    bit  mon_m1_quiet = 0;
    bit  mon_wr = 0;
    int  m1_rvalid_cnt = 0;
    int  m0_arready_cnt = 0;
    int  b_count = 0;
    rexp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_arvalid && s_arready) begin
                if (grant_q.size() > 0) begin
                    mon_who = m0_arready ? 0 : (m1_arready ? 1 : 3);
                    checkOutput("grant_order", mon_who, grant_q.pop_front());
                end
                if (bubble_en && last_rfire_cyc >= 0)
                    checkOutput("idle_bubble", cyc - last_rfire_cyc, 2);
            end
            if (m0_rvalid && m0_rready) begin
                last_rfire_cyc = cyc;
                if (q0.size() == 0) checkOutput("m0_r_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    checkOutput("m0_rdata", m0_rdata, e.data);
                    checkOutput("m0_rresp", m0_rresp, e.resp);
                    checkOutput("m0_rid", m0_rid, e.id);
                    checkOutput("m0_rlast", m0_rlast, 1);
                end
            end
            if (m1_rvalid && m1_rready) begin
                last_rfire_cyc = cyc;
                if (q1.size() == 0) checkOutput("m1_r_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    checkOutput("m1_rdata", m1_rdata, e.data);
                    checkOutput("m1_rresp", m1_rresp, e.resp);
                    checkOutput("m1_rid", m1_rid, e.id);
                    checkOutput("m1_rlast", m1_rlast, 1);
                end
            end
            if (m1_bvalid && m1_bready) begin
                b_count++;
                if (bq.size() == 0) checkOutput("m1_b_unexpected", 1, 0);
                else checkOutput("m1_bresp", m1_bresp, bq.pop_front());
            end
            if (mon_m1_quiet && m1_rvalid) m1_rvalid_cnt++;
            if (mon_wr && m0_arready) m0_arready_cnt++;
        end
    end

    // Issues one read on the chosen master, queues its expected response
    // when track is set, and holds arvalid until the handshake.
    task automatic applyStimulus(input int mst, input logic [31:0] addr, input logic [3:0] id,
                                 input logic [31:0] exp_data, input logic [1:0] exp_resp,
                                 input bit track);
        rexp_t x;
        bit fired;
        x.data = exp_data;
        x.resp = exp_resp;
        x.id   = id;
        fired  = 0;
        if (mst == 0) begin
            if (track) q0.push_back(x);
            m0_araddr = addr; m0_arid = id; m0_arvalid = 1'b1;
        end else begin
            if (track) q1.push_back(x);
            m1_araddr = addr; m1_arid = id; m1_arvalid = 1'b1;
        end
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clk);
            fired = (mst == 0) ? (m0_arvalid && m0_arready) : (m1_arvalid && m1_arready);
        end
        if (!fired) checkOutput("ar_timeout", 0, 1);
        @(posedge clk); #1;
        if (mst == 0) m0_arvalid = 1'b0;
        else          m1_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 1;
        for (int i = 0; i < 200 && n != 0; i++) begin
            @(negedge clk);
            n = q0.size() + q1.size() + bq.size() + grant_q.size();
        end
        if (n != 0) checkOutput("drain_timeout", n, 0);
        @(posedge clk); #1;
    endtask

    // Repeatedly re-requests as soon as the previous response arrives.
    task automatic contend(input int mst);
        bit seen;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mst, (mst == 0 ? 32'h8000_0000 : 32'h9000_0000) + 32'(i * 4),
                          4'(i + mst * 8),
                          mem_word((mst == 0 ? 32'h8000_0000 : 32'h9000_0000) + 32'(i * 4)),
                          RESP_OKAY, 1);
            seen = 0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(negedge clk);
                seen = (mst == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready);
            end
            if (!seen) checkOutput("r_timeout", 0, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit aw_f, w_f;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_quiet",
                    {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
                     m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);

        $display("[TB] simultaneous reads after reset");
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            applyStimulus(0, 32'h1001_0000, 4'd1, sl_mtime[31:0] + 32'd1, RESP_OKAY, 1);
            applyStimulus(1, 32'h1001_0004, 4'd2, 32'h0, RESP_OKAY, 1);
        join
        wait_idle();

        $display("[TB] m0-only mtime read");
        repeat (100) @(posedge clk);
        #1 mon_m1_quiet = 1;
        applyStimulus(0, 32'h1001_0000, 4'd3, sl_mtime[31:0] + 32'd1, RESP_OKAY, 1);
        wait_idle();
        mon_m1_quiet = 0;
        checkOutput("m1_rvalid_quiet", m1_rvalid_cnt, 0);

        $display("[TB] LSU write, w ahead of aw");
        mon_wr = 1;
        b_count = 0;
        bq.push_back(RESP_OKAY);
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        m1_awaddr = 32'h1001_0000; m1_awvalid = 1'b1;
        aw_f = 0; w_f = 0;
        for (int i = 0; i < 100 && !(aw_f && w_f); i++) begin
            @(negedge clk);
            if (m1_awvalid && m1_awready) aw_f = 1;
            if (m1_wvalid && m1_wready)   w_f = 1;
            @(posedge clk); #1;
            if (aw_f) m1_awvalid = 1'b0;
            if (w_f)  m1_wvalid  = 1'b0;
        end
        if (!(aw_f && w_f)) checkOutput("aw_w_timeout", {aw_f, w_f}, 2'b11);
        wait_idle();
        repeat (3) @(posedge clk);
        mon_wr = 0;
        checkOutput("single_b", b_count, 1);
        checkOutput("m0_arready_wr", m0_arready_cnt, 0);
        checkOutput("slave_wdata", sl_wdata, 32'hDEAD_BEEF);
        checkOutput("slave_wstrb", sl_wstrb, 4'hF);
        checkOutput("slave_awaddr", sl_awaddr, 32'h1001_0000);

        $display("[TB] error passthrough");
        #1 applyStimulus(1, 32'h1001_0008, 4'd5, 32'h0, RESP_SLVERR, 1);
        wait_idle();

        $display("[TB] sustained contention");
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(0);
            grant_q.push_back(1);
        end
        last_rfire_cyc = -1;
        bubble_en = 1;
        fork
            contend(0);
            contend(1);
        join
        wait_idle();
        bubble_en = 0;

        $display("[TB] reset mid-read");
        m0_rready = 1'b0;
        applyStimulus(0, 32'h8000_0100, 4'd7, 32'h0, RESP_OKAY, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m0_rready = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_quiet",
                    {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
                     m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
        @(posedge clk); #1;
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            applyStimulus(0, 32'h8000_0200, 4'd1, mem_word(32'h8000_0200), RESP_OKAY, 1);
            applyStimulus(1, 32'h9000_0200, 4'd2, mem_word(32'h9000_0200), RESP_OKAY, 1);
        join
        wait_idle();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
